instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 115 +++++++++++
 tb/tb_instr_prefetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - instruction byte prefetch queue between program ROM and decoder
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [15:0]              rom_addr,
    input  logic [7:0]               rom_data,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [15:0]              redirect_addr,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [15:0]              out_addr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [15:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         data_q [DEPTH];
    logic [7:0]         data_d [DEPTH];
    logic [15:0]        addr_q [DEPTH];
    logic [15:0]        addr_d [DEPTH];
    logic               push;
    logic               pop;

    // Operating state is a pure decode of fetch_en and occupancy; no extra history is needed.
    always_comb begin
        state = FETCH;
        if (!fetch_en) begin
            state = IDLE;
        end else if (count_q == DEPTH_C) begin
            state = FULL;
        end
    end

    // Queue and fetch-pointer update: redirect flushes and overrides both push and pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_d     = data_q;
        addr_d     = addr_q;

        pop  = (count_q != '0) && out_ready && !redirect_valid;
        // A full queue can still accept a byte when the head leaves in the same cycle.
        push = (state != IDLE) && !redirect_valid && ((state != FULL) || pop);

        if (redirect_valid) begin
            fetch_pc_d = redirect_addr;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = rom_data;
                addr_d[wr_ptr_q] = fetch_pc_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                fetch_pc_d       = fetch_pc_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 8'h00;
                addr_q[i] <= 16'h0000;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
        end
    end

    assign rom_addr  = fetch_pc_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_addr  = addr_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - scoreboard bench for instr_prefetch
module tb_instr_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic                   clk;
    logic                   rst_n;
    logic [15:0]            rom_addr;
    logic [7:0]             rom_data;
    logic                   fetch_en;
    logic                   redirect_valid;
    logic [15:0]            redirect_addr;
    logic                   out_valid;
    logic [7:0]             out_data;
    logic [15:0]            out_addr;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_q [$];
    logic [23:0] sb_q [$];
    logic [15:0] m_pc;

    instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_addr       (out_addr),
        .out_ready      (out_ready),
        .count          (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h01;
            16'h0001: return 8'h00;
            16'h0002: return 8'h16;
            16'h0003: return 8'h48;
            16'h0004: return 8'hFC;
            default:  return a[7:0] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    always_comb rom_data = rom_byte(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {addr,data} following the push/pop/redirect rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            m_pc = RESET_PC;
        end else if (redirect_valid) begin
            m_q.delete();
            sb_q.delete();
            m_pc = redirect_addr;
        end else begin
            bit p_pop, p_push;
            p_pop  = (m_q.size() != 0) && out_ready;
            p_push = fetch_en && ((m_q.size() < DEPTH) || p_pop);
            if (p_pop) void'(m_q.pop_front());
            if (p_push) begin
                m_q.push_back({m_pc, rom_byte(m_pc)});
                sb_q.push_back({m_pc, rom_byte(m_pc)});
                m_pc = m_pc + 16'd1;
            end
        end
    end

    // Monitor: compare the presented head with the scoreboard, retire it on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mon_count", 32'(count), 32'(m_q.size()));
            check("mon_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("mon_rom_addr", 32'(rom_addr), 32'(m_pc));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("mon_sb_nonempty", 32'(sb_q.size()), 32'd1);
                end else begin
                    check("mon_head", {8'h00, out_addr, out_data}, 32'(sb_q[0]));
                    if (out_ready && !redirect_valid) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_addr", 32'(out_addr), 32'h0000);
        check("rst_rom_addr", 32'(rom_addr), 32'(RESET_PC));
        tick(2);
        rst_n = 1'b1;

        // Fill with consumer stalled, then one simultaneous push+pop at full.
        fetch_en = 1'b1;
        tick(4);
        check("fill_count", 32'(count), 32'd4);
        check("fill_rom_addr", 32'(rom_addr), 32'h0004);
        check("fill_head", {8'h00, out_addr, out_data}, 32'h0000_01);
        tick(1);
        check("full_hold_head", {8'h00, out_addr, out_data}, 32'h0000_01);
        check("full_hold_pc", 32'(rom_addr), 32'h0004);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pushpop_count", 32'(count), 32'd4);
        check("pushpop_head", {8'h00, out_addr, out_data}, 32'h0001_00);
        check("pushpop_pc", 32'(rom_addr), 32'h0005);

        // Streaming: one-cycle latency, count steady at 1.
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stream_count", 32'(count), 32'd1);
            check("stream_head", {8'h00, out_addr, out_data}, {8'h00, 16'(i), rom_byte(16'(i))});
        end

        // Redirect while three entries queued and consumer ready.
        do_reset();
        fetch_en = 1'b1;
        tick(3);
        check("redir_pre_count", 32'(count), 32'd3);
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0002;
        out_ready      = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        check("redir_count", 32'(count), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("redir_head", {8'h00, out_addr, out_data}, 32'h0002_16);

        // Wrap of fetch_pc past 0xFFFF.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFF;
        tick(1);
        redirect_valid = 1'b0;
        check("wrap_rom_addr0", 32'(rom_addr), 32'hFFFF);
        tick(2);
        check("wrap_count", 32'(count), 32'd2);
        check("wrap_head", 32'(out_addr), 32'hFFFF);
        check("wrap_rom_addr2", 32'(rom_addr), 32'h0001);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("wrap_second", 32'(out_addr), 32'h0000);

        // Back-to-back redirects: last one wins.
        redirect_valid = 1'b1;
        redirect_addr  = 16'h1234;
        tick(1);
        redirect_addr  = 16'h0100;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        check("b2b_head", 32'(out_addr), 32'h0100);
        check("b2b_count", 32'(count), 32'd1);

        // fetch_en low: pc holds, pops drain queue.
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        tick(3);
        check("drain_count", 32'(count), 32'd0);
        check("drain_pc", 32'(rom_addr), 32'h0101);

        // Asynchronous reset between edges.
        do_reset();
        fetch_en = 1'b1;
        tick(2);
        fetch_en = 1'b0;
        check("async_pre_count", 32'(count), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_rom_addr", 32'(rom_addr), 32'(RESET_PC));
        check("async_data", 32'(out_data), 32'h00);
        tick(1);
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        tick(1);
        check("post_rst_push", 32'(count), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            fetch_en       = ($urandom_range(0, 9) < 8);
            out_ready      = $urandom_range(0, 1) == 1;
            redirect_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_addr = 16'hFFFE;
                1:       redirect_addr = 16'hFFFF;
                default: redirect_addr = 16'($urandom);
            endcase
            tick(1);
        end
        redirect_valid = 1'b0;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
